mainfsm: RTL and testbench
==========================

# mainfsm

Multicycle ARM main control state machine. Sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives the multicycle datapath's mux selects and write strobes. Its raw RegW, MemW and Branch strobes feed the conditional-execution logic, which gates them with CondEx. A MemReady handshake lets a variable-latency instruction/data memory stall the sequence.

## Interface
- No parameters.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; forces FETCH immediately
- Op  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 unsupported
- Funct  in  6  instruction bits [25:20]; Funct[5]=I (immediate), Funct[0]=L (load)
- MemReady  in  1  memory completes the current access this cycle
- IRWrite  out  1  load instruction register
- NextPC  out  1  PC update enable (PC+4)
- AdrSrc  out  1  memory address select: 0 PC, 1 ALU result
- ALUSrcA  out  2  ALU A select: 00 register, 01 PC
- ALUSrcB  out  2  ALU B select: 00 register, 01 immediate, 10 constant 4
- ALUOp  out  1  1: ALU decoder uses Funct; 0: force ADD
- ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result
- RegW  out  1  raw register write strobe
- MemW  out  1  raw memory write strobe
- Branch  out  1  raw branch strobe
- State  out  4  current state code, for debug/verification

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9. Codes 10–15 are illegal and go to FETCH on the next edge, with all outputs 0.
- Transitions:
  - FETCH → DECODE when MemReady=1; otherwise hold.
  - DECODE → MEMADR if Op=01; EXECUTEI if Op=00 and Funct[5]=1; EXECUTER if Op=00 and Funct[5]=0; BRANCH if Op=10; FETCH if Op=11 (no writes).
  - MEMADR → MEMREAD if Funct[0]=1, else MEMWRITE.
  - MEMREAD → MEMWB when MemReady=1; otherwise hold.
  - MEMWRITE → FETCH when MemReady=1; otherwise hold.
  - EXECUTER and EXECUTEI → ALUWB.
  - ALUWB, MEMWB and BRANCH → FETCH.
- Outputs are Moore, except IRWrite and NextPC. Any output not listed for a state is 0.
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10. IRWrite=NextPC=MemReady (Mealy), so the PC advances exactly once per fetch.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1 for every cycle spent in the state.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.
- Op and Funct are sampled only in DECODE and MEMADR. The instruction register must be stable from DECODE onward.

## Timing
- Reset asserted, at any time including mid-instruction: State=0 (FETCH) asynchronously. Outputs take FETCH values with IRWrite=NextPC=0 unless MemReady=1. Leaving reset takes effect on the next rising edge.
- Latencies with MemReady=1 every cycle:
  - data-processing: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - Op=11: 2 cycles
- Each cycle of MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. MemReady is ignored in all other states.
- During a stalled MEMWRITE, MemW stays high and AdrSrc stays 1; memory is responsible for committing the write once.
- RegW, MemW and Branch are one-cycle pulses per instruction, except during a MEMWRITE stall.

## Test plan
- Reset: drive reset=0 mid-MEMREAD → State=0 immediately. Release with MemReady=1 → IRWrite=1, NextPC=1 in the first cycle, then DECODE.
- ADD register (Op=00, Funct=000100), MemReady=1 → states 0,1,6,8,0. ALUOp=1 in EXECUTER; RegW=1 only in ALUWB.
- LDR (Op=01, Funct=011001), MemReady low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0. ResultSrc=01 and RegW=1 in MEMWB.
- STR (Op=01, Funct=011000) with a 1-cycle fetch stall → FETCH held 2 cycles with IRWrite=0 then 1. MemW=1 only in MEMWRITE; RegW never asserted.
- B (Op=10) → states 0,1,9,0. Branch=1 only in BRANCH, with ALUSrcA=00 and ALUSrcB=01.
- Op=11, then force an illegal state code 12 → DECODE returns to FETCH with no strobes; code 12 drives all outputs 0 and returns to FETCH next cycle.

Source files
------------

// File: rtl/mainfsm.sv
// Multicycle ARM main controller: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects plus raw RegW/MemW/Branch strobes for CondEx gating.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic [3:0] State
);

  localparam int unsigned StateW = 4;

  typedef enum logic [StateW-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_e;

  // Raw code register so unused codes 10-15 stay representable and recoverable.
  logic [StateW-1:0] state_q;
  state_e            state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  assign State = state_q;

  // Next state and Moore outputs; IRWrite/NextPC follow MemReady in FETCH.
  always_comb begin
    state_d   = FETCH;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 1'b0;
    ResultSrc = 2'b00;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    case (state_q)
      FETCH: begin
        state_d   = MemReady ? DECODE : FETCH;
        IRWrite   = MemReady;
        NextPC    = MemReady;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        state_d = Funct[0] ? MEMREAD : MEMWRITE;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        state_d = MemReady ? MEMWB : MEMREAD;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        // MemW held through stalls; memory commits the write once.
        state_d = MemReady ? FETCH : MEMWRITE;
        AdrSrc  = 1'b1;
        MemW    = 1'b1;
      end
      EXECUTER: begin
        state_d = ALUWB;
        ALUOp   = 1'b1;
      end
      EXECUTEI: begin
        state_d = ALUWB;
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      ALUWB: begin
        RegW = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: per-cycle expected output vectors are queued
// as stimulus is driven and compared against the DUT mid-cycle.
`timescale 1ns/1ps
module tb_mainfsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic       MemReady = 1'b0;
  logic       IRWrite, NextPC, AdrSrc, ALUOp, RegW, MemW, Branch;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q [$];
  logic [16:0] dut_vec;

  mainfsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .State(State)
  );

  always #5 clk = ~clk;

  assign dut_vec = {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUOp,
                    ResultSrc, RegW, MemW, Branch};

  // Reference output table for a given state code and MemReady.
  function automatic logic [16:0] model(input logic [3:0] s, input logic mr);
    logic ir, npc, adr, aop, rw, mw, br;
    logic [1:0] a, b, rs;
    {ir, npc, adr, aop, rw, mw, br} = 7'b0;
    {a, b, rs} = 6'b0;
    case (s)
      4'd0: begin ir = mr; npc = mr; a = 2'b01; b = 2'b10; rs = 2'b10; end
      4'd1: begin a = 2'b01; b = 2'b10; rs = 2'b10; end
      4'd2: begin b = 2'b01; end
      4'd3: begin adr = 1'b1; end
      4'd4: begin rs = 2'b01; rw = 1'b1; end
      4'd5: begin adr = 1'b1; mw = 1'b1; end
      4'd6: begin aop = 1'b1; end
      4'd7: begin b = 2'b01; aop = 1'b1; end
      4'd8: begin rw = 1'b1; end
      4'd9: begin b = 2'b01; rs = 2'b10; br = 1'b1; end
      default: ;
    endcase
    return {s, ir, npc, adr, a, b, aop, rs, rw, mw, br};
  endfunction

  task automatic check_eq(input string tag, input logic [16:0] got,
                          input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h (state got %0d exp %0d)",
               tag, got, exp, got[16:13], exp[16:13]);
    end
  endtask

  // One cycle: drive inputs, queue expectation, compare mid-cycle, advance.
  task automatic cyc(input string tag, input logic [1:0] op, input logic [5:0] fn,
                     input logic mr, input logic [3:0] st);
    Op = op; Funct = fn; MemReady = mr;
    exp_q.push_back(model(st, mr));
    #1;
    check_eq(tag, dut_vec, exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_seq(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [3:0] sts[], input logic mrs[]);
    for (int i = 0; i < sts.size(); i++) cyc(tag, op, fn, mrs[i], sts[i]);
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b0;
    MemReady = 1'b0;
    #1;
    exp_q.push_back(model(4'd0, 1'b0));
    check_eq("reset_idle", dut_vec, exp_q.pop_front());
    MemReady = 1'b1;
    #1;
    exp_q.push_back(model(4'd0, 1'b1));
    check_eq("reset_mr", dut_vec, exp_q.pop_front());
    @(negedge clk);
    reset = 1'b1;

    run_seq("add_reg", 2'b00, 6'b000100, '{4'd0, 4'd1, 4'd6, 4'd8}, '{1, 1, 1, 1});
    run_seq("add_imm", 2'b00, 6'b101000, '{4'd0, 4'd1, 4'd7, 4'd8}, '{1, 1, 1, 1});
    run_seq("ldr", 2'b01, 6'b011001,
            '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4}, '{1, 1, 1, 0, 0, 1, 1});
    run_seq("str", 2'b01, 6'b011000,
            '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5}, '{0, 1, 1, 1, 0, 1});
    run_seq("b", 2'b10, 6'b000000, '{4'd0, 4'd1, 4'd9}, '{1, 1, 1});
    run_seq("op11", 2'b11, 6'b111111, '{4'd0, 4'd1}, '{1, 1});

    // Reset asserted mid-MEMREAD, checked before the next edge.
    run_seq("ldr_pre", 2'b01, 6'b011001, '{4'd0, 4'd1, 4'd2, 4'd3}, '{1, 1, 1, 0});
    #2;
    reset = 1'b0;
    MemReady = 1'b1;
    #1;
    exp_q.push_back(model(4'd0, 1'b1));
    check_eq("reset_async", dut_vec, exp_q.pop_front());
    @(negedge clk);
    reset = 1'b1;
    run_seq("post_reset", 2'b10, 6'b000000, '{4'd0, 4'd1, 4'd9, 4'd0}, '{1, 1, 1, 0});

    // Illegal code 12 drives everything low and recovers to FETCH.
    force dut.state_q = 4'd12;
    MemReady = 1'b1;
    #1;
    exp_q.push_back(model(4'd12, 1'b1));
    check_eq("illegal", dut_vec, exp_q.pop_front());
    release dut.state_q;
    @(posedge clk);
    @(negedge clk);
    run_seq("recover", 2'b00, 6'b000100, '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0}, '{1, 1, 1, 1, 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
